// File: rtl/dds_pkg.sv
// Shared types and AD9833 default words for the DDS serial loader.
package dds_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      LOW,
      HIGH,
      GAP,
      DONE
   } state_t;

   // Power-up programming sequence for the AD9833, in send order
   localparam logic [15:0] AD_CTRL       = 16'h2100;
   localparam logic [15:0] AD_FREQ_LSB   = 16'h50C7;
   localparam logic [15:0] AD_FREQ_MSB   = 16'h4000;
   localparam logic [15:0] AD_PHASE      = 16'hC000;
   localparam logic [15:0] AD_EXIT_RESET = 16'h2000;

endpackage

// File: rtl/dds_word_shifter.sv
// Parallel-load, MSB-first shift register feeding one DDS word onto SDATA.
module dds_word_shifter #(
   parameter int WORD_W = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_load,
   input  logic              i_shift,
   input  logic [WORD_W-1:0] i_data,
   output logic              o_msb
);

   logic [WORD_W-1:0] r_shift;

   // Load has priority so a new word can replace a partly shifted one
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_shift <= '0;
      end else if (i_load) begin
         r_shift <= i_data;
      end else if (i_shift) begin
         r_shift <= r_shift << 1;
      end
   end

   assign o_msb = r_shift[WORD_W-1];

endmodule

// File: rtl/dds_serial_loader.sv
// Multi-word serial transaction engine driving SCLK/SDATA/FSYNC of an AD9833-class DDS.
module dds_serial_loader
   import dds_pkg::*;
#(
   parameter int WORD_W    = 16,
   parameter int NUM_WORDS = 5,
   parameter int CLK_DIV   = 2,
   parameter int FSYNC_GAP = 2
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          start,
   input  logic [$clog2(NUM_WORDS+1)-1:0] n_words,
   input  logic [NUM_WORDS*WORD_W-1:0]   words,
   output logic                          SCLK,
   output logic                          SDATA,
   output logic                          FSYNC,
   output logic                          busy,
   output logic                          done,
   output logic                          err
);

   localparam int NW_W   = $clog2(NUM_WORDS+1);
   localparam int BIT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam int PH_MAX = (CLK_DIV > FSYNC_GAP) ? CLK_DIV : FSYNC_GAP;
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   state_t                      r_state;
   logic [BIT_W-1:0]            r_bit;
   logic [PH_W-1:0]             r_phase;
   logic [NW_W-1:0]             r_wordIdx;
   logic [NW_W-1:0]             r_nWords;
   logic [NUM_WORDS*WORD_W-1:0] r_words;

   logic              w_startOk;
   logic              w_phaseEnd;
   logic              w_lastBit;
   logic              w_moreWords;
   logic              w_frame;
   logic              w_load;
   logic              w_shift;
   logic              w_msb;
   logic [NW_W-1:0]   w_nextIdx;
   logic [WORD_W-1:0] w_loadData;

   assign w_startOk   = start && (n_words != '0) && (n_words <= NW_W'(NUM_WORDS));
   assign w_phaseEnd  = (r_phase == '0);
   assign w_lastBit   = (r_bit == BIT_W'(WORD_W-1));
   assign w_nextIdx   = r_wordIdx + NW_W'(1);
   assign w_moreWords = (w_nextIdx != r_nWords);
   assign w_frame     = (r_state == SETUP) || (r_state == LOW) || (r_state == HIGH);

   // The first word comes straight from the inputs, later ones from the latched copy
   assign w_load  = ((r_state == IDLE) && w_startOk)
                 || ((r_state == GAP) && w_phaseEnd && w_moreWords);
   assign w_shift = (r_state == LOW) && w_phaseEnd && !w_lastBit;

   always_comb begin
      w_loadData = '0;
      if (r_state == IDLE) begin
         w_loadData = words[WORD_W-1:0];
      end else begin
         w_loadData = r_words[int'(w_nextIdx)*WORD_W +: WORD_W];
      end
   end

   dds_word_shifter #(
      .WORD_W (WORD_W)
   ) u_shifter (
      .clk     (clk),
      .rstn    (rstn),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (w_loadData),
      .o_msb   (w_msb)
   );

   // Pin outputs follow the state one cycle later, so FSYNC falls the edge after start
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_bit     <= '0;
         r_phase   <= '0;
         r_wordIdx <= '0;
         r_nWords  <= '0;
         r_words   <= '0;
         SCLK      <= 1'b1;
         SDATA     <= 1'b0;
         FSYNC     <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         SCLK  <= (r_state != LOW);
         FSYNC <= !w_frame;
         SDATA <= w_frame && w_msb;
         done  <= (r_state == DONE);
         err   <= (r_state == IDLE) && start && !w_startOk;
         busy  <= (r_state == IDLE) ? w_startOk : (r_state != DONE);

         unique case (r_state)
            IDLE: begin
               if (w_startOk) begin
                  r_words   <= words;
                  r_nWords  <= n_words;
                  r_wordIdx <= '0;
                  r_bit     <= '0;
                  r_phase   <= PH_W'(CLK_DIV-1);
                  r_state   <= SETUP;
               end
            end
            SETUP: begin
               if (w_phaseEnd) begin
                  r_phase <= PH_W'(CLK_DIV-1);
                  r_state <= LOW;
               end else begin
                  r_phase <= r_phase - PH_W'(1);
               end
            end
            LOW: begin
               if (w_phaseEnd) begin
                  if (w_lastBit) begin
                     r_phase <= PH_W'(FSYNC_GAP-1);
                     r_state <= GAP;
                  end else begin
                     r_bit   <= r_bit + BIT_W'(1);
                     r_phase <= PH_W'(CLK_DIV-1);
                     r_state <= HIGH;
                  end
               end else begin
                  r_phase <= r_phase - PH_W'(1);
               end
            end
            HIGH: begin
               if (w_phaseEnd) begin
                  r_phase <= PH_W'(CLK_DIV-1);
                  r_state <= LOW;
               end else begin
                  r_phase <= r_phase - PH_W'(1);
               end
            end
            GAP: begin
               if (w_phaseEnd) begin
                  if (w_moreWords) begin
                     r_wordIdx <= w_nextIdx;
                     r_bit     <= '0;
                     r_phase   <= PH_W'(CLK_DIV-1);
                     r_state   <= SETUP;
                  end else begin
                     r_phase <= '0;
                     r_state <= DONE;
                  end
               end else begin
                  r_phase <= r_phase - PH_W'(1);
               end
            end
            DONE: begin
               r_phase <= '0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dds_serial_loader.sv
// Self-checking bench for dds_serial_loader: vector table plus scoreboard of framed words.
module tb_dds_serial_loader;
   import dds_pkg::*;

   localparam int NW_W      = 3;
   localparam int FRAME_LOW = 64;

   typedef struct {
      int          n;
      logic [79:0] words;
      bit          expErr;
      int          expLatency;
      int          mode;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rstnA, startA, sclkA, sdataA, fsyncA, busyA, doneA, errA;
   logic [NW_W-1:0] nWordsA;
   logic [79:0]     wordsA;
   logic            rstnB, startB, sclkB, sdataB, fsyncB, busyB, doneB, errB;
   logic [NW_W-1:0] nWordsB;
   logic [79:0]     wordsB;

   dds_serial_loader #(.WORD_W(16), .NUM_WORDS(5), .CLK_DIV(2), .FSYNC_GAP(2)) dutA (
      .clk(clk), .rstn(rstnA), .start(startA), .n_words(nWordsA), .words(wordsA),
      .SCLK(sclkA), .SDATA(sdataA), .FSYNC(fsyncA), .busy(busyA), .done(doneA), .err(errA)
   );

   dds_serial_loader #(.WORD_W(16), .NUM_WORDS(5), .CLK_DIV(1), .FSYNC_GAP(1)) dutB (
      .clk(clk), .rstn(rstnB), .start(startB), .n_words(nWordsB), .words(wordsB),
      .SCLK(sclkB), .SDATA(sdataB), .FSYNC(fsyncB), .busy(busyB), .done(doneB), .err(errB)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] expQ[$];
   logic        prevSclk = 1'b1;
   logic        prevFsync = 1'b1;
   logic [15:0] capWord = '0;
   int          capBits = 0;
   int          lowCyc = 0;
   int          frameCount = 0;
   bit          abortPending = 1'b0;
   vec_t        vecs[7];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Frame monitor: collects bits on SCLK falling edges and scores each word at FSYNC rise
   always @(negedge clk) begin
      if (fsyncA === 1'b0) begin
         lowCyc++;
         if (prevSclk && !sclkA) begin
            capWord = {capWord[14:0], sdataA};
            capBits++;
         end
      end
      if (!prevFsync && fsyncA) begin
         if (abortPending) begin
            expQ.delete();
            abortPending = 1'b0;
         end else begin
            checkOutput("frameBits", capBits, 16);
            checkOutput("frameLowCycles", lowCyc, FRAME_LOW);
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL frameData: got unexpected word %0h expected no frame", capWord);
            end else begin
               checkOutput("frameData", capWord, expQ.pop_front());
            end
         end
         frameCount++;
         capBits = 0;
         lowCyc  = 0;
         capWord = '0;
      end
      prevSclk  = sclkA;
      prevFsync = fsyncA;
   end

   task automatic runReject(input vec_t v);
      int errCount = 0;
      int fsyncLow = 0;
      bit doneSeen = 0;
      @(negedge clk);
      nWordsA = NW_W'(v.n);
      startA  = 1'b1;
      @(negedge clk);
      startA = 1'b0;
      checkOutput("errPulse", errA, 1);
      checkOutput("busyOnReject", busyA, 0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (errA) errCount++;
         if (!fsyncA) fsyncLow++;
         if (doneA) doneSeen = 1;
      end
      checkOutput("errPulseWidth", errCount, 0);
      checkOutput("fsyncOnReject", fsyncLow, 0);
      checkOutput("doneOnReject", doneSeen, 0);
   endtask

   task automatic runTxn(input vec_t v);
      int          tLow = -1;
      int          latency = 0;
      bit          errSeen = 0;
      bit          doneSeen = 0;
      logic [79:0] w;
      w = v.words;
      @(negedge clk);
      for (int k = 0; k < v.n; k++) expQ.push_back(w[k*16 +: 16]);
      nWordsA = NW_W'(v.n);
      wordsA  = v.words;
      startA  = 1'b1;
      @(negedge clk);
      startA = 1'b0;
      checkOutput("busyAfterStart", busyA, 1);
      checkOutput("fsyncLatency", fsyncA, 1);
      errSeen = errA;
      for (int k = 0; k < 5000 && !doneSeen; k++) begin
         @(negedge clk);
         if (!fsyncA && tLow < 0) tLow = cyc;
         if (errA) errSeen = 1;
         if (v.mode == 1) begin
            if (k == 20) begin
               nWordsA = '0;
               startA  = 1'b1;
            end else if (k == 60) begin
               nWordsA = NW_W'(5);
               wordsA  = '1;
               startA  = 1'b1;
            end else begin
               startA = 1'b0;
            end
         end
         if (v.mode == 2 && k == 10) begin
            wordsA  = '1;
            nWordsA = NW_W'(1);
         end
         if (doneA) begin
            doneSeen = 1;
            latency  = cyc - tLow;
         end
      end
      startA = 1'b0;
      if (!doneSeen) begin
         checks++;
         errors++;
         $display("[TB] FAIL doneTimeout: got no done expected done after %0d cycles", v.expLatency);
      end else begin
         checkOutput("doneLatency", latency, v.expLatency);
         checkOutput("busyAtDone", busyA, 0);
         @(negedge clk);
         checkOutput("donePulseWidth", doneA, 0);
      end
      checkOutput("errWhileBusy", errSeen, 0);
      checkOutput("scoreboardDrained", expQ.size(), 0);
   endtask

   task automatic applyStimulus(input vec_t v);
      if (v.expErr) runReject(v);
      else runTxn(v);
   endtask

   task automatic resetMidTransfer();
      int f0;
      bit reached = 0;
      bit doneSeen = 0;
      f0 = frameCount;
      @(negedge clk);
      for (int k = 0; k < 5; k++) expQ.push_back(vecs[0].words[k*16 +: 16]);
      nWordsA = NW_W'(5);
      wordsA  = vecs[0].words;
      startA  = 1'b1;
      @(negedge clk);
      startA = 1'b0;
      for (int k = 0; k < 1000 && !reached; k++) begin
         @(negedge clk);
         if (frameCount - f0 == 2 && capBits >= 7) reached = 1;
      end
      if (!reached) begin
         checks++;
         errors++;
         $display("[TB] FAIL abortPoint: got no bit 7 of word 2 expected it within 1000 cycles");
      end
      abortPending = 1'b1;
      rstnA = 1'b0;
      @(negedge clk);
      rstnA = 1'b1;
      checkOutput("abortFsync", fsyncA, 1);
      checkOutput("abortSclk", sclkA, 1);
      checkOutput("abortSdata", sdataA, 0);
      checkOutput("abortBusy", busyA, 0);
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (doneA) doneSeen = 1;
      end
      checkOutput("doneAfterAbort", doneSeen, 0);
   endtask

   task automatic fastSingleWord();
      int          tLow = -1;
      int          latency = 0;
      int          bits = 0;
      int          nonToggle = 0;
      bit          doneSeen = 0;
      logic        pSclk;
      logic [15:0] cap = '0;
      @(negedge clk);
      nWordsB = NW_W'(1);
      wordsB  = {64'h0, 16'hA5A5};
      startB  = 1'b1;
      @(negedge clk);
      startB = 1'b0;
      pSclk  = sclkB;
      for (int k = 0; k < 200 && !doneSeen; k++) begin
         @(negedge clk);
         if (!fsyncB) begin
            if (tLow < 0) tLow = cyc;
            else if (sclkB == pSclk) nonToggle++;
            if (pSclk && !sclkB) begin
               cap = {cap[14:0], sdataB};
               bits++;
            end
         end
         pSclk = sclkB;
         if (doneB) begin
            doneSeen = 1;
            latency  = cyc - tLow;
         end
      end
      checkOutput("fastData", cap, 16'hA5A5);
      checkOutput("fastBits", bits, 16);
      checkOutput("fastSclkToggle", nonToggle, 0);
      checkOutput("fastDoneSeen", doneSeen, 1);
      checkOutput("fastDoneLatency", latency, 33);
   endtask

   initial begin
      rstnA = 1'b0; startA = 1'b0; nWordsA = '0; wordsA = '0;
      rstnB = 1'b0; startB = 1'b0; nWordsB = '0; wordsB = '0;

      vecs[0] = '{5, {AD_EXIT_RESET, AD_PHASE, AD_FREQ_MSB, AD_FREQ_LSB, AD_CTRL}, 1'b0, 330, 0};
      vecs[1] = '{0, 80'h0, 1'b1, 0, 0};
      vecs[2] = '{2, {48'h0, 16'h8001, 16'h7E3C}, 1'b0, 132, 1};
      vecs[3] = '{6, 80'h0, 1'b1, 0, 0};
      vecs[4] = '{3, {32'h0, 16'hDEAD, 16'hBEEF, 16'h0F0F}, 1'b0, 198, 2};
      vecs[5] = '{1, {64'h0, 16'h8000}, 1'b0, 66, 0};
      vecs[6] = '{7, 80'h0, 1'b1, 0, 0};

      repeat (3) @(negedge clk);
      checkOutput("resetSclk", sclkA, 1);
      checkOutput("resetFsync", fsyncA, 1);
      checkOutput("resetSdata", sdataA, 0);
      checkOutput("resetBusy", busyA, 0);
      checkOutput("resetDone", doneA, 0);
      checkOutput("resetErr", errA, 0);
      checkOutput("resetFsyncB", fsyncB, 1);
      rstnA = 1'b1;
      rstnB = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

      resetMidTransfer();
      applyStimulus(vecs[0]);

      fastSingleWord();

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
